// File: rtl/shifter_rotator_pipe_if.sv
// Operand/result bus of the pipelined shifter: input op handshake, result handshake and flush.
interface shifter_rotator_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int SHW = $clog2(WIDTH);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;

    modport slave (
        input  flush, in_valid, in_data, in_amt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero
    );

    modport master (
        output flush, in_valid, in_data, in_amt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero
    );
endinterface

// File: rtl/shifter_rotator_pipe.sv
// Fully pipelined barrel shifter/rotator: bit-reverse in, log2(WIDTH) left-shift stages, bit-reverse out.
module shifter_rotator_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    shifter_rotator_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int NS  = SHW + 1;

    // Index 0 is the input (reversed) stage, index k+1 holds the result of shift stage k.
    logic [WIDTH-1:0] dat_q [NS];
    logic [SHW-1:0]   amt_q [NS];
    logic [2:0]       op_q  [NS];
    logic [TAG_W-1:0] tag_q [NS];
    logic             sgn_q [NS];
    logic [NS:0]      vld_q;
    logic [WIDTH-1:0] out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_zero_q;

    logic [WIDTH-1:0] shf_d [SHW];
    logic [WIDTH-1:0] res_d;
    logic             stall;
    logic             accept;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
        return r;
    endfunction

    assign stall        = vld_q[NS] & ~bus.out_ready;
    assign bus.in_ready = ~stall & ~bus.flush;
    assign accept       = bus.in_valid & bus.in_ready;

    // Right ops run in the reversed domain, so every stage only ever shifts left.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            shf_d[k] = dat_q[k];
            if (amt_q[k][k]) begin
                if (op_q[k][1])
                    shf_d[k] = (dat_q[k] << (1 << k)) | (dat_q[k] >> (WIDTH - (1 << k)));
                else if (op_q[k][2] && op_q[k][0])
                    shf_d[k] = (dat_q[k] << (1 << k)) |
                               ({WIDTH{sgn_q[k]}} & ~({WIDTH{1'b1}} << (1 << k)));
                else
                    shf_d[k] = dat_q[k] << (1 << k);
            end
        end
    end

    assign res_d = op_q[SHW][0] ? bit_rev(dat_q[SHW]) : dat_q[SHW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            out_data_q <= '0;
            out_tag_q  <= '0;
            out_zero_q <= 1'b0;
            for (int s = 0; s < NS; s++) begin
                dat_q[s] <= '0;
                amt_q[s] <= '0;
                op_q[s]  <= '0;
                tag_q[s] <= '0;
                sgn_q[s] <= 1'b0;
            end
        end else begin
            if (bus.flush)
                vld_q <= '0;
            else if (!stall)
                vld_q <= {vld_q[NS-1:0], accept};

            if (!stall) begin
                dat_q[0] <= bus.in_op[0] ? bit_rev(bus.in_data) : bus.in_data;
                amt_q[0] <= bus.in_amt;
                op_q[0]  <= bus.in_op;
                tag_q[0] <= bus.in_tag;
                sgn_q[0] <= bus.in_data[WIDTH-1];
                for (int s = 1; s < NS; s++) begin
                    dat_q[s] <= shf_d[s-1];
                    amt_q[s] <= amt_q[s-1];
                    op_q[s]  <= op_q[s-1];
                    tag_q[s] <= tag_q[s-1];
                    sgn_q[s] <= sgn_q[s-1];
                end
                out_data_q <= res_d;
                out_tag_q  <= tag_q[SHW];
                out_zero_q <= (res_d == '0);
            end
        end
    end

    assign bus.out_valid = vld_q[NS];
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_zero  = out_zero_q;
endmodule

// File: tb/tb_shifter_rotator_pipe.sv
// Bench for shifter_rotator_pipe: directed vectors, random stream vs. arithmetic model, flush/reset, WIDTH=8.
module tb_shifter_rotator_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shifter_rotator_pipe_if #(.WIDTH(32), .TAG_W(4)) bus ();
    shifter_rotator_pipe_if #(.WIDTH(8),  .TAG_W(4)) bus8 ();

    shifter_rotator_pipe #(.WIDTH(32), .TAG_W(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    shifter_rotator_pipe #(.WIDTH(8),  .TAG_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  amt;
        logic [2:0]  op;
        logic [3:0]  tag;
        logic [31:0] exp;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
    } exp_t;

    vec_t vecs [15];
    exp_t q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain shift/rotate arithmetic on the whole word.
    function automatic logic [31:0] model32(input logic [31:0] d, input int a, input logic [2:0] op);
        logic [63:0]        dd;
        logic [63:0]        t;
        logic signed [31:0] s;
        dd = {d, d};
        s  = d;
        if (op[1]) begin
            if (op[0]) begin t = dd >> a; return t[31:0]; end
            else       begin t = dd << a; return t[63:32]; end
        end else if (op == 3'b101) return s >>> a;
        else if (op[0]) return d >> a;
        else return d << a;
    endfunction

    task automatic single32(input logic [31:0] d, input logic [4:0] a, input logic [2:0] op,
                            input logic [3:0] tag, input logic [31:0] exp, input logic z,
                            input string nm);
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_amt = a; bus.in_op = op; bus.in_tag = tag;
        bus.out_ready = 1'b1;
        #1 chk({nm, "_in_ready"}, bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin @(negedge clk); lat++; end
        chk({nm, "_out_valid"}, bus.out_valid, 1);
        chk({nm, "_latency"}, lat, 7);
        chk({nm, "_data"}, bus.out_data, exp);
        chk({nm, "_tag"}, bus.out_tag, tag);
        chk({nm, "_zero"}, bus.out_zero, z);
    endtask

    task automatic single8(input logic [7:0] d, input logic [2:0] a, input logic [2:0] op,
                           input logic [3:0] tag, input logic [7:0] exp, input string nm);
        int lat;
        @(negedge clk);
        bus8.in_valid = 1'b1; bus8.in_data = d; bus8.in_amt = a; bus8.in_op = op; bus8.in_tag = tag;
        bus8.out_ready = 1'b1;
        #1 chk({nm, "_in_ready"}, bus8.in_ready, 1);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 20) begin @(negedge clk); lat++; end
        chk({nm, "_out_valid"}, bus8.out_valid, 1);
        chk({nm, "_latency"}, lat, 5);
        chk({nm, "_data"}, bus8.out_data, exp);
        chk({nm, "_tag"}, bus8.out_tag, tag);
    endtask

    initial begin
        int          pend, issued, cyc, seen;
        logic        prev_stall;
        logic [31:0] cd;
        logic [4:0]  ca;
        logic [2:0]  co;
        logic [3:0]  ct;

        vecs[0]  = '{32'h8000_0001, 5'd1,  3'b000, 4'd0,  32'h0000_0002, 1'b0};
        vecs[1]  = '{32'h8000_0000, 5'd31, 3'b101, 4'd1,  32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{32'h8000_0000, 5'd31, 3'b001, 4'd2,  32'h0000_0001, 1'b0};
        vecs[3]  = '{32'h0000_0001, 5'd1,  3'b011, 4'd3,  32'h8000_0000, 1'b0};
        vecs[4]  = '{32'h8000_0000, 5'd4,  3'b010, 4'd4,  32'h0000_0008, 1'b0};
        vecs[5]  = '{32'h1234_5678, 5'd0,  3'b101, 4'd5,  32'h1234_5678, 1'b0};
        vecs[6]  = '{32'h1234_5678, 5'd0,  3'b011, 4'd6,  32'h1234_5678, 1'b0};
        vecs[7]  = '{32'h8000_0001, 5'd1,  3'b100, 4'd7,  32'h0000_0002, 1'b0};
        vecs[8]  = '{32'h0000_0001, 5'd1,  3'b111, 4'd8,  32'h8000_0000, 1'b0};
        vecs[9]  = '{32'hF000_0000, 5'd4,  3'b110, 4'd9,  32'h0000_000F, 1'b0};
        vecs[10] = '{32'h7FFF_FFFF, 5'd31, 3'b101, 4'd10, 32'h0000_0000, 1'b1};
        vecs[11] = '{32'h0000_0001, 5'd31, 3'b000, 4'd11, 32'h8000_0000, 1'b0};
        vecs[12] = '{32'h8765_4321, 5'd8,  3'b001, 4'd12, 32'h0087_6543, 1'b0};
        vecs[13] = '{32'h8765_4321, 5'd8,  3'b101, 4'd13, 32'hFF87_6543, 1'b0};
        vecs[14] = '{32'h0000_00FF, 5'd28, 3'b011, 4'd14, 32'h0000_0FF0, 1'b0};

        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0;
        bus.in_op = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
        bus8.flush = 1'b0; bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_amt = '0;
        bus8.in_op = '0; bus8.in_tag = '0; bus8.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_out_zero", bus.out_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_release_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 15; i++)
            single32(vecs[i].d, vecs[i].amt, vecs[i].op, vecs[i].tag, vecs[i].exp, vecs[i].z,
                     $sformatf("vec%0d", i));

        // Random stream with out_ready toggling; the head of q must be on out_* whenever valid.
        pend = 0; issued = 0; cyc = 0; prev_stall = 1'b0;
        cd = '0; ca = '0; co = '0; ct = '0;
        while ((issued < 300 || q.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            if (pend == 0 && issued < 300 && $urandom_range(0, 3) != 0) begin
                cd = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                ca = 5'($urandom_range(0, 31));
                co = 3'($urandom_range(0, 7));
                ct = 4'($urandom_range(0, 15));
                pend = 1;
            end
            bus.in_valid = (pend != 0);
            bus.in_data = cd; bus.in_amt = ca; bus.in_op = co; bus.in_tag = ct;
            bus.out_ready = (issued >= 300) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) chk("stall_hold_valid", bus.out_valid, 1);
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rand_spurious_out actual tag=%0h required no output", bus.out_tag);
                end else begin
                    chk("rand_data", bus.out_data, q[0].d);
                    chk("rand_tag", bus.out_tag, q[0].t);
                    chk("rand_zero", bus.out_zero, (q[0].d == 32'h0));
                    if (bus.out_ready) void'(q.pop_front());
                end
            end
            prev_stall = bus.out_valid & ~bus.out_ready;
            if (pend != 0 && bus.in_ready) begin
                q.push_back('{model32(cd, int'(ca), co), ct});
                pend = 0;
                issued++;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("rand_issued", issued, 300);
        chk("rand_drained", q.size(), 0);

        // Flush with five ops in flight, plus an input offered during the flush cycle.
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'(i + 1); bus.in_amt = '0;
            bus.in_op = 3'b000; bus.in_tag = 4'(9 + i);
            #1 chk("flush_fill_ready", bus.in_ready, 1);
            @(negedge clk);
        end
        bus.flush = 1'b1; bus.in_tag = 4'd14;
        #1 chk("flush_in_ready", bus.in_ready, 0);
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        #1 chk("flush_out_valid", bus.out_valid, 0);
        seen = 0;
        repeat (12) begin @(negedge clk); if (bus.out_valid) seen++; end
        chk("flush_no_emerge", seen, 0);
        single32(32'h0000_0055, 5'd1, 3'b000, 4'd3, 32'h0000_00AA, 1'b0, "post_flush");

        // Reset in the middle of a stream; nothing issued before it may appear afterwards.
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'hA5A5_0000 + 32'(i); bus.in_amt = 5'd2;
            bus.in_op = 3'b001; bus.in_tag = 4'(i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_data", bus.out_data, 0);
        chk("midrst_out_zero", bus.out_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_in_ready", bus.in_ready, 1);
        single32(32'h0, 5'd3, 3'b000, 4'd2, 32'h0, 1'b1, "midrst_sll0");

        single8(8'h81, 3'd1, 3'b011, 4'd5, 8'hC0, "w8_ror");
        single8(8'h80, 3'd7, 3'b101, 4'd6, 8'hFF, "w8_sra");
        single8(8'h01, 3'd7, 3'b000, 4'd7, 8'h80, "w8_sll");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
